// File: rtl/spi_peripheral_pkg.sv
// Shared constants and types for the SPI register-write target.
package spi_peripheral_pkg;

  // Frame length in sclk edges: R/W bit, 7-bit address, 8-bit data.
  localparam int FRAME_BITS = 16;

  // Register map addresses.
  localparam int ADDR_EN_OUT_LO = 'h00;
  localparam int ADDR_EN_OUT_HI = 'h01;
  localparam int ADDR_EN_PWM_LO = 'h02;
  localparam int ADDR_EN_PWM_HI = 'h03;
  localparam int ADDR_DUTY      = 'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle
// rising and falling edge pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;

  // Next-state: shift the pin into the chain, remember last synchronised level.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], din};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target writing the five 8-bit PWM control registers.
// Optional read-back of registers on cipo is enabled by defining
// SPI_READBACK_EN; without it cipo is tied low and read frames are ignored.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_peripheral_pkg::FRAME_BITS,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [6:0] MAX_ADDR_A  = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL    = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT     = 5'(FRAME_BITS + 1);
  localparam logic [1:0] SETTLE_DONE = 2'(SYNC_STAGES);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ncs_sync, ncs_rise, ncs_fall;
  logic copi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk (clk), .rst (rst), .din (sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
    .clk (clk), .rst (rst), .din (ncs),
    .sync(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
  );

  // copi needs only a level: same depth as sclk so data and edge stay aligned.
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;

  // copi synchroniser next-state.
  always_comb copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};

  // copi synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) copi_sync_q <= '0;
    else     copi_sync_q <= copi_sync_d;
  end

  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  state_e                   state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [15:0]              shift_q, shift_d;
  logic [MAX_ADDR:0][7:0]   regs_q, regs_d;
  logic [1:0]               settle_q, settle_d;
  logic                     armed_q, armed_d;

  // Frame FSM next-state. A reset that lands while ncs is held low makes the
  // synchronised ncs fall from its reset value of 1; armed_q blocks that fake
  // edge so the remainder of an interrupted frame is never captured.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    regs_d   = regs_q;
    settle_d = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == SETTLE_DONE) & ncs_sync);
    case (state_q)
      IDLE: begin
        if (ncs_fall && armed_q) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // ncs rise wins over a coincident sclk edge.
        if (ncs_rise) begin
          state_d = (cnt_q == CNT_FULL) ? COMMIT : IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      COMMIT: begin
        if (shift_q[15] && (shift_q[14:8] <= MAX_ADDR_A)) begin
          for (int i = 0; i <= MAX_ADDR; i++) begin
            if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM, shifter, counter and register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      regs_q   <= '0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      regs_q   <= regs_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] tx_q, tx_d;
  logic       act_q, act_d;
  logic       cipo_q, cipo_d;
  logic [7:0] hdr;
  logic       load_ok;

  // Read-back shifter: load on the 8th sclk rise of a read header, hold bit7
  // through the following fall, then advance one bit per fall.
  always_comb begin
    tx_d    = tx_q;
    act_d   = act_q;
    hdr     = {shift_q[6:0], copi_s};
    load_ok = (state_q == SHIFT) && !ncs_rise && sclk_rise && (cnt_q == 5'd7) &&
              !hdr[7] && (hdr[6:0] <= MAX_ADDR_A);
    if (load_ok) begin
      tx_d = '0;
      for (int i = 0; i <= MAX_ADDR; i++) begin
        if (hdr[6:0] == 7'(i)) tx_d = regs_q[i];
      end
      act_d = 1'b1;
    end else if (act_q && sclk_fall) begin
      if (cnt_q >= CNT_FULL)  act_d = 1'b0;
      else if (cnt_q >= 5'd9) tx_d = {tx_q[6:0], 1'b0};
    end
    if (state_d != SHIFT) act_d = 1'b0;
    cipo_d = act_d & tx_d[7];
  end

  // Read-back shifter and registered cipo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= '0;
      act_q  <= 1'b0;
      cipo_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      act_q  <= act_d;
      cipo_q <= cipo_d;
    end
  end

  assign cipo = cipo_q;

  logic unused_sig;
  assign unused_sig = sclk_sync;
`else
  assign cipo = 1'b0;

  logic unused_sig;
  assign unused_sig = sclk_sync ^ sclk_fall;
`endif

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY];

  // A commit only ever follows a frame of exactly FRAME_BITS edges.
  a_commit_len: assert property (@(posedge clk) disable iff (rst)
    (state_q == COMMIT) |-> (cnt_q == CNT_FULL));

endmodule
